// File: rtl/chip8_seq_ctrl.sv
// CHIP-8 fetch/dispatch sequencer: owns the PC and call stack, fetches two-byte
// instructions, resolves flow control locally and hands other opcodes to execute.
module chip8_seq_ctrl #(
    parameter logic [11:0] RESET_PC    = 12'h200,
    parameter int unsigned STACK_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_rd_req,
    output logic [11:0] mem_addr,
    input  logic        mem_rd_ack,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] instruction,
    output logic        instr_valid,
    input  logic [5:0]  decode,
    input  logic [11:0] addr_in,
    input  logic [7:0]  v0,
    output logic        exec_start,
    input  logic        exec_done,
    input  logic        skip,
    output logic [11:0] pc,
    output logic [4:0]  sp,
    output logic        fault
);

    localparam int unsigned PC_W  = 12;
    localparam int unsigned SP_W  = 5;
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [5:0] OP_INVALID = 6'd0;
    localparam logic [5:0] OP_RET     = 6'd2;
    localparam logic [5:0] OP_JMP     = 6'd3;
    localparam logic [5:0] OP_CALL    = 6'd4;
    localparam logic [5:0] OP_JMP_V0  = 6'd21;

    typedef enum logic [2:0] {
        FETCH_HI,
        FETCH_LO,
        DEC_WAIT,
        DISPATCH,
        EXEC_WAIT,
        FAULT
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      hi_q, hi_d;
    logic [PC_W-1:0] pc_d, mem_addr_d;
    logic [SP_W-1:0] sp_d;
    logic [15:0]     instr_d;
    logic            req_d, ivalid_d, estart_d, fault_d;
    logic            rd_accept_c, push_c;
    logic [PC_W-1:0] stack [STACK_DEPTH];

    // Next-state, datapath and strobe decode
    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        pc_d        = pc;
        sp_d        = sp;
        instr_d     = instruction;
        fault_d     = fault;
        ivalid_d    = 1'b0;
        estart_d    = 1'b0;
        push_c      = 1'b0;
        // An ack only counts while our request is actually up
        rd_accept_c = mem_rd_req && mem_rd_ack;

        case (state_q)
            FETCH_HI: begin
                if (rd_accept_c) begin
                    hi_d    = mem_rdata;
                    state_d = FETCH_LO;
                end
            end
            FETCH_LO: begin
                if (rd_accept_c) begin
                    instr_d  = {hi_q, mem_rdata};
                    ivalid_d = 1'b1;
                    state_d  = DEC_WAIT;
                end
            end
            DEC_WAIT: state_d = DISPATCH;
            DISPATCH: begin
                state_d = FETCH_HI;
                case (decode)
                    OP_JMP:    pc_d = addr_in;
                    OP_CALL: begin
                        if (sp == SP_W'(STACK_DEPTH)) begin
                            fault_d = 1'b1;
                            state_d = FAULT;
                        end else begin
                            push_c = 1'b1;
                            sp_d   = sp + SP_W'(1);
                            pc_d   = addr_in;
                        end
                    end
                    OP_RET: begin
                        if (sp == '0) begin
                            fault_d = 1'b1;
                            state_d = FAULT;
                        end else begin
                            sp_d = sp - SP_W'(1);
                            pc_d = stack[IDX_W'(sp - SP_W'(1))];
                        end
                    end
                    OP_JMP_V0:  pc_d = addr_in + {4'h0, v0};
                    OP_INVALID: pc_d = pc + PC_W'(2);
                    default: begin
                        estart_d = 1'b1;
                        state_d  = EXEC_WAIT;
                    end
                endcase
            end
            EXEC_WAIT: begin
                // exec_done coinciding with the start pulse is illegal and dropped
                if (exec_done && !exec_start) begin
                    pc_d    = pc + (skip ? PC_W'(4) : PC_W'(2));
                    state_d = FETCH_HI;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = FETCH_HI;
        endcase

        req_d      = ((state_d == FETCH_HI) || (state_d == FETCH_LO)) && !rd_accept_c;
        mem_addr_d = (state_d == FETCH_LO) ? pc_d + PC_W'(1) : pc_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FETCH_HI;
            hi_q        <= '0;
            pc          <= RESET_PC;
            sp          <= '0;
            instruction <= '0;
            instr_valid <= 1'b0;
            exec_start  <= 1'b0;
            mem_rd_req  <= 1'b0;
            mem_addr    <= RESET_PC;
            fault       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            pc          <= pc_d;
            sp          <= sp_d;
            instruction <= instr_d;
            instr_valid <= ivalid_d;
            exec_start  <= estart_d;
            mem_rd_req  <= req_d;
            mem_addr    <= mem_addr_d;
            fault       <= fault_d;
        end
    end

    // Return-address storage; contents need no reset
    always_ff @(posedge clk) begin
        if (push_c) begin
            stack[IDX_W'(sp)] <= pc + PC_W'(2);
        end
    end

endmodule

// File: tb/tb_chip8_seq_ctrl.sv
// Scoreboard bench for chip8_seq_ctrl: expected fetches/instructions/checks are
// queued by the stimulus and compared by a single negedge monitor.
module tb_chip8_seq_ctrl;

    localparam logic [5:0] OP_INV    = 6'd0;
    localparam logic [5:0] OP_RET    = 6'd2;
    localparam logic [5:0] OP_JMP    = 6'd3;
    localparam logic [5:0] OP_CALL   = 6'd4;
    localparam logic [5:0] OP_EXEC   = 6'd5;
    localparam logic [5:0] OP_JMP_V0 = 6'd21;

    typedef struct packed {
        logic [5:0]  op;
        logic [11:0] a;
        logic [7:0]  v;
    } op_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_rd_req;
    logic [11:0] mem_addr;
    logic        mem_rd_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic [15:0] instruction;
    logic        instr_valid;
    logic [5:0]  decode = 6'd0;
    logic [11:0] addr_in = 12'h000;
    logic [7:0]  v0 = 8'h00;
    logic        exec_start;
    logic        exec_done;
    logic        skip = 1'b0;
    logic [11:0] pc;
    logic [4:0]  sp;
    logic        fault;

    logic [7:0]  mem [4096];
    int          grant_cnt = 0;
    int          used_cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          exec_seen = 0;
    int          exec_delay = 3;
    logic        exec_skip_cfg = 1'b0;
    logic        ex_busy = 1'b0;
    int          ex_cnt = 0;
    logic        ex_skip = 1'b0;
    logic        ex_done_q = 1'b0;
    logic        stray_done = 1'b0;
    logic        prev_iv = 1'b0;
    logic        prev_es = 1'b0;

    logic [15:0] exp_addr_q[$];
    logic [15:0] exp_instr_q[$];
    op_t         op_q[$];
    string       name_q[$];
    logic [15:0] act_q[$];
    logic [15:0] expv_q[$];

    assign exec_done = ex_done_q | stray_done;

    always #5 clk = ~clk;

    chip8_seq_ctrl #(.RESET_PC(12'h200), .STACK_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_rd_ack(mem_rd_ack), .mem_rdata(mem_rdata),
        .instruction(instruction), .instr_valid(instr_valid),
        .decode(decode), .addr_in(addr_in), .v0(v0),
        .exec_start(exec_start), .exec_done(exec_done), .skip(skip),
        .pc(pc), .sp(sp), .fault(fault)
    );

    // Program memory: acks one cycle after a request, only within granted budget
    always @(posedge clk) begin
        if (!rst) begin
            mem_rd_ack <= 1'b0;
            used_cnt   <= 0;
        end else begin
            mem_rd_ack <= 1'b0;
            if (mem_rd_req && !mem_rd_ack && grant_cnt > used_cnt) begin
                mem_rd_ack <= 1'b1;
                mem_rdata  <= mem[mem_addr];
                used_cnt   <= used_cnt + 1;
            end
        end
    end

    // Execute unit model: done with skip a configurable number of cycles after start
    always @(posedge clk) begin
        if (!rst) begin
            ex_busy   <= 1'b0;
            ex_cnt    <= 0;
            ex_done_q <= 1'b0;
            skip      <= 1'b0;
        end else begin
            ex_done_q <= 1'b0;
            skip      <= 1'b0;
            if (ex_busy) begin
                if (ex_cnt <= 1) begin
                    ex_done_q <= 1'b1;
                    skip      <= ex_skip;
                    ex_busy   <= 1'b0;
                end else begin
                    ex_cnt <= ex_cnt - 1;
                end
            end else if (exec_start) begin
                ex_busy <= 1'b1;
                ex_cnt  <= exec_delay;
                ex_skip <= exec_skip_cfg;
            end
        end
    end

    // Decode stage model: fields valid the cycle after instr_valid
    always @(negedge clk) begin
        op_t cur;
        if (instr_valid && op_q.size() > 0) begin
            cur     = op_q.pop_front();
            decode  = cur.op;
            addr_in = cur.a;
            v0      = cur.v;
        end
    end

    task automatic do_chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endtask

    // Monitor: sole owner of the comparison counters
    always @(negedge clk) begin
        if (rst) begin
            if (mem_rd_req && mem_rd_ack) begin
                if (exp_addr_q.size() > 0) do_chk("fetch_addr", 16'(mem_addr), exp_addr_q.pop_front());
                else                       do_chk("fetch_unexpected", 16'(mem_addr), 16'hFFFF);
            end
            if (instr_valid) begin
                if (exp_instr_q.size() > 0) do_chk("instruction", instruction, exp_instr_q.pop_front());
                else                        do_chk("instr_unexpected", 16'(instr_valid), 16'd0);
            end
            if (prev_iv) do_chk("instr_valid_pulse", 16'(instr_valid), 16'd0);
            if (prev_es) do_chk("exec_start_pulse", 16'(exec_start), 16'd0);
            if (exec_start) begin
                exec_seen++;
                do_chk("iv_with_es", 16'(instr_valid), 16'd0);
            end
        end
        while (name_q.size() > 0)
            do_chk(name_q.pop_front(), act_q.pop_front(), expv_q.pop_front());
        prev_iv = instr_valid;
        prev_es = exec_start;
    end

    task automatic post(input string nm, input logic [15:0] act, input logic [15:0] expv);
        name_q.push_back(nm);
        act_q.push_back(act);
        expv_q.push_back(expv);
    endtask

    function automatic logic [15:0] word_at(input logic [11:0] a);
        logic [11:0] b;
        b = a + 12'd1;
        return {mem[a], mem[b]};
    endfunction

    task automatic do_reset();
        rst       = 1'b0;
        grant_cnt = 0;
        stray_done = 1'b0;
        exp_addr_q.delete();
        exp_instr_q.delete();
        op_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Issue one instruction fetched at pc_now and wait for the sequencer to settle
    task automatic run_instr(input logic [11:0] pc_now, input logic [5:0] op, input logic [11:0] a,
                             input logic [7:0] vv, input logic [15:0] exp_instr,
                             input logic [11:0] exp_pc, input logic exp_fault);
        logic [11:0] lo;
        logic        done;
        op_t         o;
        lo   = pc_now + 12'd1;
        o.op = op;
        o.a  = a;
        o.v  = vv;
        exp_addr_q.push_back(16'(pc_now));
        exp_addr_q.push_back(16'(lo));
        exp_instr_q.push_back(exp_instr);
        op_q.push_back(o);
        grant_cnt = grant_cnt + 2;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (exp_fault) done = fault;
            else done = mem_rd_req && (op_q.size() == 0) && (exp_addr_q.size() == 0)
                        && (grant_cnt == used_cnt) && !ex_busy;
        end
        post("settle", 16'(done), 16'd1);
        post("pc", 16'(pc), 16'(exp_pc));
        post("fault", 16'(fault), 16'(exp_fault));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] p, tgt;
        logic        bad, done;
        int          es0;

        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h200] = 8'h12;
        mem[12'h201] = 8'h34;
        mem[12'hFFF] = 8'hAB;
        mem[12'h000] = 8'hCD;

        // Reset values
        rst = 1'b0;
        repeat (3) @(negedge clk);
        post("rst_pc", 16'(pc), 16'h0200);
        post("rst_sp", 16'(sp), 16'd0);
        post("rst_fault", 16'(fault), 16'd0);
        post("rst_instruction", instruction, 16'h0000);
        post("rst_instr_valid", 16'(instr_valid), 16'd0);
        post("rst_exec_start", 16'(exec_start), 16'd0);
        post("rst_mem_rd_req", 16'(mem_rd_req), 16'd0);
        rst = 1'b1;
        @(negedge clk);

        // JMP 0x234 from 0x200
        run_instr(12'h200, OP_JMP, 12'h234, 8'h00, 16'h1234, 12'h234, 1'b0);
        post("jmp_next_fetch", 16'(mem_addr), 16'h0234);
        post("jmp_sp", 16'(sp), 16'd0);

        // CALL 0x300 then RET
        do_reset();
        run_instr(12'h200, OP_CALL, 12'h300, 8'h00, 16'h1234, 12'h300, 1'b0);
        post("call_sp", 16'(sp), 16'd1);
        run_instr(12'h300, OP_RET, 12'h000, 8'h00, 16'h0000, 12'h202, 1'b0);
        post("ret_sp", 16'(sp), 16'd0);

        // Stack overflow on the 17th nested CALL
        do_reset();
        p = 12'h200;
        for (int i = 0; i < 16; i++) begin
            tgt = 12'h400 + 12'(i * 16);
            run_instr(p, OP_CALL, tgt, 8'h00, word_at(p), tgt, 1'b0);
            p = tgt;
        end
        post("full_sp", 16'(sp), 16'd16);
        run_instr(p, OP_CALL, 12'h600, 8'h00, word_at(p), p, 1'b1);
        post("ovf_sp", 16'(sp), 16'd16);
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            bad = bad | mem_rd_req | exec_start;
        end
        post("fault_quiet", 16'(bad), 16'd0);
        post("fault_pc_frozen", 16'(pc), 16'(p));

        // Stack underflow
        do_reset();
        run_instr(12'h200, OP_RET, 12'h000, 8'h00, 16'h1234, 12'h200, 1'b1);
        post("unf_sp", 16'(sp), 16'd0);

        // Execute handoff with and without skip, then an invalid opcode
        do_reset();
        run_instr(12'h200, OP_JMP, 12'h210, 8'h00, 16'h1234, 12'h210, 1'b0);
        es0 = exec_seen;
        exec_delay = 3;
        exec_skip_cfg = 1'b1;
        run_instr(12'h210, OP_EXEC, 12'h000, 8'h00, word_at(12'h210), 12'h214, 1'b0);
        post("exec_start_count", 16'(exec_seen - es0), 16'd1);
        exec_skip_cfg = 1'b0;
        run_instr(12'h214, OP_EXEC, 12'h000, 8'h00, word_at(12'h214), 12'h216, 1'b0);
        post("exec_start_count2", 16'(exec_seen - es0), 16'd2);
        run_instr(12'h216, OP_INV, 12'h000, 8'h00, word_at(12'h216), 12'h218, 1'b0);
        post("invalid_no_exec", 16'(exec_seen - es0), 16'd2);

        // JMP_V0 wrap and fetch across the top of memory
        run_instr(12'h218, OP_JMP_V0, 12'hFF0, 8'h20, word_at(12'h218), 12'h010, 1'b0);
        run_instr(12'h010, OP_JMP, 12'hFFF, 8'h00, word_at(12'h010), 12'hFFF, 1'b0);
        run_instr(12'hFFF, OP_INV, 12'h000, 8'h00, 16'hABCD, 12'h001, 1'b0);

        // Reset during EXEC_WAIT, stray exec_done right after release
        do_reset();
        exec_delay = 40;
        es0 = exec_seen;
        exp_addr_q.push_back(16'h0200);
        exp_addr_q.push_back(16'h0201);
        exp_instr_q.push_back(16'h1234);
        op_q.push_back('{op: OP_EXEC, a: 12'h000, v: 8'h00});
        grant_cnt = grant_cnt + 2;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = (exec_seen != es0);
        end
        post("reach_exec_wait", 16'(done), 16'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        grant_cnt = 0;
        repeat (2) @(negedge clk);
        post("mid_rst_pc", 16'(pc), 16'h0200);
        rst = 1'b1;
        stray_done = 1'b1;
        es0 = exec_seen;
        repeat (3) @(negedge clk);
        stray_done = 1'b0;
        post("post_rst_pc", 16'(pc), 16'h0200);
        post("post_rst_sp", 16'(sp), 16'd0);
        post("post_rst_fault", 16'(fault), 16'd0);
        post("post_rst_no_exec", 16'(exec_seen - es0), 16'd0);
        post("post_rst_fetch_req", 16'(mem_rd_req), 16'd1);
        post("post_rst_fetch_addr", 16'(mem_addr), 16'h0200);
        exec_delay = 3;
        run_instr(12'h200, OP_JMP, 12'h234, 8'h00, 16'h1234, 12'h234, 1'b0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
